// File: rtl/dmem_uart_dump_if.sv
// -----------------------------------------------------------------------------
// dmem_uart_dump_if
//   Data-memory synchronous read port, shared by the dump engine and the data
//   memory beside it.
//
//   mem_rd_en    read strobe (driven by the reader)
//   mem_addr     word address (driven by the reader)
//   mem_rd_data  read data, valid the cycle after mem_rd_en (driven by memory)
//
//   modport master : the dump engine (issues reads)
//   modport slave  : the data memory (answers reads)
// -----------------------------------------------------------------------------
interface dmem_uart_dump_if #(
    parameter int ADDR_WIDTH = 8
);

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rd_data;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data
    );

endinterface

// File: rtl/dmem_uart_dump.sv
// -----------------------------------------------------------------------------
// dmem_uart_dump
//   Read-back engine for the CPU data memory. On a start request it walks
//   word_count words beginning at base_addr through the memory's synchronous
//   read port and sends each word on a UART line (8N1, LSB first, bytes in
//   little-endian order).
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per UART bit (must be >= 2)
//     ADDR_WIDTH    data-memory word-address width
//
//   Ports
//     clk         system clock, rising edge
//     rst         synchronous active-low reset
//     start       one-cycle dump request, honoured only when idle
//     base_addr   first word address, sampled with start
//     word_count  number of words to send, sampled with start
//     dmem        data-memory read port (master side)
//     tx          UART serial output, idles high
//     busy        high from the cycle after an accepted start through done
//     done        one-cycle pulse at the end of a dump
// -----------------------------------------------------------------------------
module dmem_uart_dump #(
    parameter int CLKS_PER_BIT = 4,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    dmem_uart_dump_if.master      dmem,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int DATA_WIDTH = 32;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WORD_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [ADDR_WIDTH-1:0]   addr;        // current word address
    logic [ADDR_WIDTH:0]     remaining;   // words still to be read
    logic [DATA_WIDTH-1:0]   shift_word;  // word being sent, bit 0 is on the line
    logic [1:0]              byte_idx;    // byte of the word being sent
    logic [2:0]              bit_idx;     // data bit of the byte being sent
    logic [CNT_W-1:0]        clk_cnt;     // cycles elapsed in the current bit
    logic                    bit_end;
    logic                    rd_en;

    // The last cycle of a bit period; every line change happens here so each
    // bit is exactly CLKS_PER_BIT cycles wide.
    assign bit_end = (clk_cnt == CNT_LAST);

    assign dmem.mem_rd_en = rd_en;
    assign dmem.mem_addr  = addr;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (word_count == '0) ? S_FINISH : S_READ;
                end
            end

            S_READ: begin
                rd_en      = 1'b1;
                state_next = S_LATCH;
            end

            S_LATCH: begin
                state_next = S_START;
            end

            S_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end

            S_DATA: begin
                tx = shift_word[0];
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx != 2'd3) begin
                        state_next = S_START;
                    end else if (remaining != '0) begin
                        state_next = S_READ;
                    end else begin
                        state_next = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: address, word counter, shift word, bit timing
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr       <= '0;
            remaining  <= '0;
            shift_word <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            clk_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                    end
                end

                S_LATCH: begin
                    shift_word <= dmem.mem_rd_data;
                    byte_idx   <= '0;
                    bit_idx    <= '0;
                    clk_cnt    <= '0;
                    remaining  <= remaining - WORD_ONE;
                    addr       <= addr + ADDR_ONE;   // wraps at the top of memory
                end

                S_START: begin
                    clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
                end

                S_DATA: begin
                    clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
                    if (bit_end) begin
                        // Shifting the whole word means byte N+1 lands on bit 0
                        // after byte N's eight bits; bit_idx wraps back to 0.
                        shift_word <= {1'b0, shift_word[DATA_WIDTH-1:1]};
                        bit_idx    <= bit_idx + 3'd1;
                    end
                end

                S_STOP: begin
                    clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
                    if (bit_end && (byte_idx != 2'd3)) begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end

                default: begin
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_uart_dump.sv
// -----------------------------------------------------------------------------
// tb_dmem_uart_dump
//   Scoreboard bench for dmem_uart_dump. Each dump request pushes the reads,
//   serial bytes (with their start-bit cycle) and done cycle that the dump
//   must produce; independent monitors pop and compare as the DUT presents
//   them. A second instance with CLKS_PER_BIT = 7 checks bit widths.
// -----------------------------------------------------------------------------
module tb_dmem_uart_dump;

    localparam int AW       = 8;
    localparam int C        = 4;
    localparam int C7       = 7;
    localparam int WORD_CYC = 40 * C + 2;
    localparam int TIMEOUT  = 4000;

    typedef struct {
        int          cyc;
        logic [7:0]  data;
    } byte_exp_t;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          tx, busy, done;
    logic [31:0]   ram [256];

    dmem_uart_dump_if #(.ADDR_WIDTH(AW)) mem_bus ();

    dmem_uart_dump #(.CLKS_PER_BIT(C), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .dmem       (mem_bus),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk)
        if (mem_bus.mem_rd_en) mem_bus.mem_rd_data <= ram[mem_bus.mem_addr];

    // bit-width DUT
    logic          start7 = 1'b0;
    logic [AW-1:0] base7 = '0;
    logic [AW:0]   count7 = (AW + 1)'(1);
    logic          tx7, busy7, done7;
    logic [31:0]   ram7 [256];

    dmem_uart_dump_if #(.ADDR_WIDTH(AW)) mem7_bus ();

    dmem_uart_dump #(.CLKS_PER_BIT(C7), .ADDR_WIDTH(AW)) dut7 (
        .clk        (clk),
        .rst        (rst),
        .start      (start7),
        .base_addr  (base7),
        .word_count (count7),
        .dmem       (mem7_bus),
        .tx         (tx7),
        .busy       (busy7),
        .done       (done7)
    );

    always @(posedge clk)
        if (mem7_bus.mem_rd_en) mem7_bus.mem_rd_data <= ram7[mem7_bus.mem_addr];

    // scoreboard state
    int        n_vec = 0;
    int        n_err = 0;
    byte_exp_t byte_q[$];
    rd_exp_t   rd_q[$];
    int        done_q[$];
    int        busy_lo = 1;
    int        busy_hi = 0;
    int        abort_cyc = -1;
    int        last_t0 = 0;

    int        run7 = 0;
    logic      tx7_prev = 1'b1;
    bit        seen_fall7 = 1'b0;
    int        fall7_cyc = -1;
    int        first_run7 = -1;
    int        n_done7 = 0;
    int        exp_done7 = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue a dump at the current negedge and record what it must produce.
    task automatic issue(input int base, input int cnt);
        int            t0;
        int            a;
        logic [31:0]   w;
        byte_exp_t     be;
        rd_exp_t       re;
        t0      = cyc;
        last_t0 = t0;
        busy_lo = t0 + 1;
        if (cnt == 0) begin
            busy_hi = t0 + 1;
        end else begin
            for (int k = 0; k < cnt; k++) begin
                a       = (base + k) % 256;
                re.cyc  = t0 + 1 + k * WORD_CYC;
                re.addr = AW'(a);
                rd_q.push_back(re);
                w = ram[a];
                for (int j = 0; j < 4; j++) begin
                    be.cyc  = t0 + 3 + k * WORD_CYC + j * 10 * C;
                    be.data = 8'((w >> (8 * j)) & 32'hFF);
                    byte_q.push_back(be);
                end
            end
            busy_hi = t0 + 3 + cnt * 40 * C + 2 * (cnt - 1);
        end
        done_q.push_back(busy_hi);
        base_addr  = AW'(base);
        word_count = (AW + 1)'(cnt);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || cyc <= busy_hi) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) check("idle_timeout", busy, 0);
    endtask

    task automatic pulse_start_mid(input int base, input int cnt);
        base_addr  = AW'(base);
        word_count = (AW + 1)'(cnt);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // busy / idle line / done / read-port monitor
    initial begin : cycle_monitor
        logic    exp_busy;
        rd_exp_t re;
        forever begin
            @(negedge clk);
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            check("busy", busy, exp_busy);
            if (!exp_busy) check("tx_idle", tx, 1);
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
            if (mem_bus.mem_rd_en === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read: got read of 0x%0h at cycle %0d, want none", mem_bus.mem_addr, cyc);
                end else begin
                    re = rd_q.pop_front();
                    check("rd_cycle", cyc, re.cyc);
                    check("rd_addr", mem_bus.mem_addr, re.addr);
                end
            end
        end
    end

    // UART decoder for the main DUT
    initial begin : uart_decoder
        int         sc;
        logic       sb, stp;
        logic [7:0] d;
        byte_exp_t  be;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                sc = cyc;
                repeat (C / 2) @(negedge clk);
                sb = tx;
                for (int b = 0; b < 8; b++) begin
                    repeat (C) @(negedge clk);
                    d[b] = tx;
                end
                repeat (C) @(negedge clk);
                stp = tx;
                if (sc > abort_cyc) begin
                    if (byte_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h starting cycle %0d, want none", d, sc);
                    end else begin
                        be = byte_q.pop_front();
                        check("byte_start_cycle", sc, be.cyc);
                        check("byte_start_bit", sb, 0);
                        check("byte_data", d, be.data);
                        check("byte_stop_bit", stp, 1);
                    end
                end
            end
        end
    end

    // Run-length monitor for the CLKS_PER_BIT = 7 instance
    initial begin : width_monitor
        forever begin
            @(negedge clk);
            if (tx7 !== tx7_prev) begin
                if (seen_fall7) begin
                    if (first_run7 < 0) first_run7 = run7;
                    check("dut7_run_len_mod7", run7 % C7, 0);
                end else if (tx7 === 1'b0) begin
                    seen_fall7 = 1'b1;
                    fall7_cyc  = cyc;
                end
                run7 = 1;
            end else begin
                run7++;
            end
            tx7_prev = tx7;
            if (done7 === 1'b1) begin
                n_done7++;
                check("dut7_done_cycle", cyc, exp_done7);
            end
        end
    end

    initial begin : stimulus
        int n;
        int cnt;
        for (int i = 0; i < 256; i++) begin
            ram[i]  = $urandom;
            ram7[i] = $urandom;
        end

        // reset values
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", mem_bus.mem_rd_en, 0);
        check("reset_mem_addr", mem_bus.mem_addr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single word
        ram[0] = 32'h0000_0012;
        issue(0, 1);
        wait_idle();

        // multi-word with address wrap, issued back-to-back after done
        ram[254] = 32'hAABB_CCDD;
        ram[255] = 32'h0102_0304;
        ram[0]   = 32'hCAFE_F00D;
        issue(254, 3);
        wait_idle();

        // zero count
        issue(77, 0);
        wait_idle();

        // start while busy: must not disturb the in-flight dump
        issue(10, 2);
        repeat (60) @(negedge clk);
        pulse_start_mid(200, 5);
        repeat (150) @(negedge clk);
        pulse_start_mid(3, 0);
        wait_idle();

        // randomized dumps
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) ram[i] = $urandom;
            cnt = $urandom_range(0, 3);
            issue($urandom_range(0, 255), cnt);
            if (cnt > 0 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 120)) @(negedge clk);
                pulse_start_mid($urandom_range(0, 255), $urandom_range(0, 4));
            end
            wait_idle();
        end

        // reset during data bit 3 of byte 1
        issue($urandom_range(0, 255), 2);
        while (cyc < last_t0 + 3 + 14 * C + 1) @(negedge clk);
        rst       = 1'b0;
        abort_cyc = cyc;
        busy_hi   = cyc;
        byte_q.delete();
        rd_q.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mem_addr", mem_bus.mem_addr, 0);
        rst = 1'b1;
        repeat (20 * C) @(negedge clk);
        ram[9] = $urandom;
        issue(9, 1);
        wait_idle();

        // bit width with CLKS_PER_BIT = 7; byte 0 bit 0 set isolates the start bit
        ram7[0]   = $urandom | 32'h1;
        exp_done7 = cyc + 3 + 40 * C7;
        fall7_cyc = -1;
        start7    = 1'b1;
        @(negedge clk);
        start7    = 1'b0;
        n = 0;
        while (n_done7 == 0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("dut7_done_pulses", n_done7, 1);
        check("dut7_first_fall_cycle", fall7_cyc, exp_done7 - 40 * C7);
        check("dut7_start_bit_len", first_run7, C7);

        // nothing left unconsumed
        check("bytes_outstanding", byte_q.size(), 0);
        check("reads_outstanding", rd_q.size(), 0);
        check("dones_outstanding", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_uart_dump.md
# dmem_uart_dump

Read-back engine for the CPU's data memory. On command it walks a range of data-memory words through the memory's synchronous read port and serialises each word over a UART transmit line (8N1, LSB first, little-endian byte order). It sits beside the data memory in `cpu_uart_top`, opposite the UART program loader. The loader writes memory from the serial line; this block reads memory back out to it, so results of store instructions can be observed off-chip.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit; legal values are ≥ 2.
- `ADDR_WIDTH`, default 8: data-memory word-address width.
- `DATA_WIDTH`, fixed at 32: memory word width; 4 bytes per word.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle dump request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; sampled with `start`.
- `word_count`  in  ADDR_WIDTH+1  number of words to send; sampled with `start`.
- `mem_rd_en`  out  1  data-memory read strobe.
- `mem_addr`  out  ADDR_WIDTH  data-memory word address.
- `mem_rd_data`  in  32  read data, valid the cycle after `mem_rd_en`.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse at the end of a dump.

## Operation
- **States:** IDLE, READ, LATCH, START, DATA, STOP, FINISH.
- **IDLE**
  - `tx` = 1, `busy` = 0.
  - When `start` = 1, latch `base_addr` into the address counter and `word_count` into the remaining-word counter.
  - If the count is nonzero, go to READ; if it is 0, go to FINISH.
- **READ:** assert `mem_rd_en` = 1 with `mem_addr` = current address for exactly one cycle, then go to LATCH.
- **LATCH**
  - Capture `mem_rd_data` into the 32-bit shift word.
  - Set byte index = 0, decrement the remaining count, increment the address.
  - The address increment wraps modulo 2^ADDR_WIDTH.
  - Go to START.
- **START:** `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - Drive 8 bits of the current byte, LSB first, each for CLKS_PER_BIT cycles.
  - Byte 0 is word[7:0] and byte 3 is word[31:24].
- **STOP:** `tx` = 1 for CLKS_PER_BIT cycles. At the end of the stop bit:
  - if byte index < 3: increment the byte index and go to START (no inter-byte gap);
  - else if words remain: go to READ;
  - else: go to FINISH.
- **FINISH:** `done` = 1 and `busy` = 1 for one cycle, then go to IDLE.
- `start` is ignored in every state other than IDLE.
- `mem_rd_en` = 0 in every state other than READ.
- `mem_addr` holds the current address in all states.
- **Reset** (`rst` = 0 at a clock edge, in any state including mid-bit):
  - next state IDLE; `tx` = 1, `busy` = 0, `done` = 0, `mem_rd_en` = 0, `mem_addr` = 0;
  - all counters cleared;
  - no `done` pulse for an aborted dump.
- **Reset values:** `tx` = 1, `busy` = 0, `done` = 0, `mem_rd_en` = 0, `mem_addr` = 0.

## Timing
- Let T0 be the cycle in which `start` = 1 is sampled in IDLE.
  - T1: READ (`mem_rd_en` = 1, `mem_addr` = base).
  - T2: LATCH.
  - T3: first cycle with `tx` = 0.
- One byte occupies exactly 10·CLKS_PER_BIT cycles.
- One word occupies 40·CLKS_PER_BIT cycles of line time.
  - Between words, `tx` stays high for 2 extra cycles (READ and LATCH).
  - The next start bit begins 2 cycles after the previous stop bit ends.
- For N ≥ 1 words, `done` is high in cycle T3 + N·40·CLKS_PER_BIT + 2·(N−1).
- For `word_count` = 0, `done` is high in T1; `tx` stays high and `mem_rd_en` is never asserted.
- `busy` rises at T1 and falls in the cycle after `done`.
- A new `start` is accepted in the cycle after `done`.
- The bit-period counter runs 0…CLKS_PER_BIT−1. `tx` changes only at counter wrap, so every bit has the same width.

## Test plan
- **Single word** (CLKS_PER_BIT = 4): ram[0] = 0x12, start with base 0, count 1.
  - Required: `mem_rd_en` at T1 with addr 0; decoded bytes 0x12, 0x00, 0x00, 0x00.
  - Required: `tx` low at T3; `done` high at T3+160.
- **Multi-word with wrap** (ADDR_WIDTH = 8): ram[254] = 0xAABBCCDD, ram[255] = 0x01020304, ram[0] = 0xCAFEF00D; base 254, count 3.
  - Required: reads at 254, 255, 0.
  - Required byte stream: DD CC BB AA 04 03 02 01 0D F0 FE CA.
  - Required: `done` at T3 + 3·160 + 4.
- **Zero count:** start with count 0.
  - Required: `done` high at T1 only; `tx` constantly 1; no `mem_rd_en`.
- **Start while busy:** pulse `start` with a different base/count mid-dump.
  - Required: the in-flight stream is unchanged, and only one `done` pulse occurs.
- **Reset mid-byte:** drive `rst` = 0 during the DATA bit 3 of byte 1.
  - Required: the next cycle has `tx` = 1, `busy` = 0, `mem_addr` = 0; no `done`.
  - Required: a subsequent start with count 1 dumps correctly.
- **Bit width:** with CLKS_PER_BIT = 7, every `tx` level run is a multiple of 7 cycles, and the start bit is exactly 7 cycles.
